// File: rtl/out_port_fifo_if.sv
// Output-port bus: processor write strobe/data in, valid/ready handshake and status out.
interface out_port_fifo_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  logic                     wr_en;
  logic [DATA_W-1:0]        wr_data;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  // Master is the processor/consumer side, slave is the FIFO.
  modport master (
    output wr_en, wr_data, out_ready,
    input  out_data, out_valid, full, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, out_ready,
    output out_data, out_valid, full, count, overflow
  );
endinterface

// File: rtl/out_port_fifo.sv
// Show-ahead output-port FIFO with sticky overflow flag.
// Define OUT_PORT_HOLD_LAST_EN to keep the last popped word on out_data while empty.
module out_port_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              rst,
  out_port_fifo_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              overflow_reg;

  logic valid, is_full, pop, push, drop;
  logic [DATA_W-1:0] head;

  assign valid   = (count_reg != '0);
  assign is_full = (count_reg == CNT_W'(DEPTH));
  assign pop     = valid && bus.out_ready;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign push    = bus.wr_en && (!is_full || pop);
  assign drop    = bus.wr_en && is_full && !pop;
  assign head    = mem_reg[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (drop) overflow_reg <= 1'b1;
    end
  end

`ifdef OUT_PORT_HOLD_LAST_EN
  logic [DATA_W-1:0] last_reg;

  always_ff @(posedge clock) begin
    if (rst) begin
      last_reg <= '0;
    end else if (pop) begin
      last_reg <= head;
    end
  end

  assign bus.out_data = valid ? head : last_reg;
`else
  assign bus.out_data = valid ? head : '0;
`endif

  assign bus.out_valid = valid;
  assign bus.full      = is_full;
  assign bus.count     = count_reg;
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_out_port_fifo.sv
// Directed plus randomized bench for out_port_fifo against a queue-based reference model.
module tb_out_port_fifo;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic clock;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [DATA_W-1:0] mq[$];
  bit                m_ovf;
  logic [DATA_W-1:0] m_last;

  out_port_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  out_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [DATA_W-1:0] exp_data;
    if (mq.size() != 0) exp_data = mq[0];
    else begin
`ifdef OUT_PORT_HOLD_LAST_EN
      exp_data = m_last;
`else
      exp_data = '0;
`endif
    end
    do_check({tag, ".valid"},    32'(bus.out_valid), 32'(mq.size() != 0));
    do_check({tag, ".count"},    32'(bus.count),     32'(mq.size()));
    do_check({tag, ".full"},     32'(bus.full),      32'(mq.size() == DEPTH));
    do_check({tag, ".overflow"}, 32'(bus.overflow),  32'(m_ovf));
    do_check({tag, ".data"},     32'(bus.out_data),  32'(exp_data));
  endtask

  // One clock: drive inputs, advance the model by the queue rules, compare all outputs.
  task automatic step(input string tag, input logic r, input logic w,
                      input logic [DATA_W-1:0] d, input logic rdy);
    bit pop, push;
    rst           = r;
    bus.wr_en     = w;
    bus.wr_data   = d;
    bus.out_ready = rdy;
    pop  = (mq.size() != 0) && rdy;
    push = w && ((mq.size() < DEPTH) || pop);
    @(posedge clock);
    #1;
    if (r) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_last = '0;
    end else begin
      if (pop) m_last = mq.pop_front();
      if (push) mq.push_back(d);
      else if (w) m_ovf = 1'b1;
    end
    rst = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.out_ready = 1'b0;
    m_ovf = 1'b0;
    m_last = '0;

    // Reset and a single word
    step("reset", 1'b1, 1'b0, 16'h0, 1'b0);
    do_check("reset_data", 32'(bus.out_data), 32'h0);
    step("single_wr", 1'b0, 1'b1, 16'h000B, 1'b0);
    do_check("single_head", 32'(bus.out_data), 32'h000B);
    step("single_pop", 1'b0, 1'b0, 16'h0, 1'b1);
    do_check("single_empty", 32'(bus.out_valid), 32'h0);

    // Fill, overflow, drain
    step("rst2", 1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 1; i <= 4; i++) step("fill", 1'b0, 1'b1, DATA_W'(i), 1'b0);
    do_check("fill_full", 32'(bus.full), 32'h1);
    step("drop", 1'b0, 1'b1, 16'h0005, 1'b0);
    do_check("drop_ovf", 32'(bus.overflow), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      do_check("drain_order", 32'(bus.out_data), 32'(i));
      step("drain", 1'b0, 1'b0, 16'h0, 1'b1);
    end
    do_check("drain_ovf_sticky", 32'(bus.overflow), 32'h1);

    // Full with simultaneous push and pop
    step("rst3", 1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 1; i <= 4; i++) step("fill2", 1'b0, 1'b1, DATA_W'(i), 1'b0);
    step("full_pushpop", 1'b0, 1'b1, 16'h0005, 1'b1);
    do_check("full_pp_count", 32'(bus.count), 32'h4);
    do_check("full_pp_ovf", 32'(bus.overflow), 32'h0);
    for (int i = 2; i <= 5; i++) begin
      do_check("drain2_order", 32'(bus.out_data), 32'(i));
      step("drain2", 1'b0, 1'b0, 16'h0, 1'b1);
    end

    // Wrap-around streaming
    for (int i = 0; i < 10; i++) begin
      step("stream", 1'b0, 1'b1, 16'h1230 + DATA_W'(i), 1'b1);
      do_check("stream_head", 32'(bus.out_data), 32'h1230 + 32'(i));
    end
    step("stream_end", 1'b0, 1'b0, 16'h0, 1'b1);

    // Reset mid-operation, with a write pending in the reset cycle
    for (int i = 0; i < 3; i++) step("prefill", 1'b0, 1'b1, 16'h00A0 + DATA_W'(i), 1'b0);
    step("mid_rst", 1'b1, 1'b1, 16'h00FF, 1'b1);
    do_check("mid_rst_count", 32'(bus.count), 32'h0);
    step("post_rst_wr", 1'b0, 1'b1, 16'h0003, 1'b0);
    do_check("post_rst_head", 32'(bus.out_data), 32'h0003);

    // Empty-output behaviour
    step("rst4", 1'b1, 1'b0, 16'h0, 1'b0);
    step("hold_wr", 1'b0, 1'b1, 16'h1234, 1'b0);
    step("hold_pop", 1'b0, 1'b0, 16'h0, 1'b1);
`ifdef OUT_PORT_HOLD_LAST_EN
    do_check("empty_data", 32'(bus.out_data), 32'h1234);
`else
    do_check("empty_data", 32'(bus.out_data), 32'h0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 60),
           DATA_W'($urandom),
           ($urandom_range(0, 99) < 50));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/out_port_fifo.md
# out_port_fifo

Output-port buffer between the processor's `write_out` bus and the external consumer. It captures each word the processor writes to its output port, queues it in a small FIFO, and presents it downstream with a valid/ready handshake. A burst of output instructions is therefore not lost while the consumer stalls. Overflow is flagged with a sticky bit rather than by stalling the processor.

## Interface
- `DATA_W`, default 16: word width; matches the processor's `write_out`.
- `DEPTH`, default 4: FIFO entries; must be a power of two, at least 2.
- `clock`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: reset; synchronous and active-high.
- `wr_en`, input, 1: processor output-port write strobe; one word per cycle when high.
- `wr_data`, input, DATA_W: processor `write_out` value, sampled when `wr_en` is high.
- `out_data`, output, DATA_W: head-of-queue word.
- `out_valid`, output, 1: `out_data` holds a valid queued word.
- `out_ready`, input, 1: consumer accepts the head word this cycle.
- `full`, output, 1: count equals DEPTH.
- `count`, output, $clog2(DEPTH)+1: number of queued words.
- `overflow`, output, 1: sticky; a write was dropped.

## Operation
- Storage is a DEPTH x DATA_W register array.
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - `count` is a separate register.
- Push: `wr_en` is high and (not full, or a pop occurs in the same cycle).
  - `wr_data` is written at the write pointer, and the write pointer increments.
- Pop: `out_valid && out_ready`.
  - The read pointer increments.
- Count update:
  - push only: count +1.
  - pop only: count −1.
  - push and pop together: count unchanged.
- Drop: `wr_en` high while full and no pop in the same cycle.
  - The word is discarded, no pointer moves, and `overflow` is set to 1.
  - `overflow` clears only on `rst`.
- `out_ready` while empty has no effect; `count` never underflows.
- `out_valid` = (count != 0). `full` = (count == DEPTH). Both are derived from the registered count.
- `out_data` = `mem[rd_ptr]` when `out_valid` is high (show-ahead; no pop latency).
- When `out_valid` is low, `out_data` follows the rule under Configuration.
- Ordering: strict FIFO; words leave in the order written.

## Timing
- Reset values: `out_valid`=0, `full`=0, `count`=0, `overflow`=0, `out_data`=0, both pointers=0. Array contents are don't-care.
- `rst` takes priority over everything else in the same cycle, including mid-burst and when full. After reset the queue is empty.
- Write-to-valid latency: 1 cycle.
  - `wr_en` sampled at edge N gives `out_valid`=1 and `out_data`=`wr_data` after edge N.
- Pop-to-next latency: the next word appears immediately after the popping edge.
- Sustained throughput: 1 word per cycle with `wr_en` and `out_ready` held high.
- Simultaneous push and pop when count==1:
  - The old head leaves and the new word becomes head after the edge.
  - `out_valid` stays 1.
- Simultaneous push and pop when full:
  - Both are accepted, `full` stays 1, and `overflow` is not set.
- The consumer may drop `out_ready` at any cycle. `out_data` holds stable while `out_valid` is high and no pop occurs.

## Configuration
- `OUT_PORT_HOLD_LAST_EN` defined:
  - When empty, `out_data` holds the last word popped (register updated on each pop).
  - It is 0 only until the first pop after reset.
- `OUT_PORT_HOLD_LAST_EN` not defined:
  - `out_data` is forced to 0 whenever `out_valid` is 0.
- Handshake, count, and overflow behaviour are identical in both builds.

## Test plan
- Reset, then a single word:
  - After reset: `out_valid`=0, `count`=0, `out_data`=0.
  - Write 16'h000B with `out_ready`=0 → `out_valid`=1, `out_data`=16'h000B, `count`=1 one cycle later.
  - Raise `out_ready` → empty the next cycle.
- Fill and overflow (DEPTH=4, `out_ready`=0):
  - Write 1, 2, 3, 4 → `full`=1, `count`=4.
  - Write 5 → dropped, `overflow`=1.
  - Drain → outputs 1, 2, 3, 4 in order; `overflow` stays 1.
- Full with simultaneous push and pop:
  - With the queue holding 1..4, write 5 with `out_ready`=1 → `count` stays 4, `overflow`=0.
  - Drain yields 2, 3, 4, 5.
- Wrap-around streaming:
  - 10 consecutive writes 16'h1230..16'h1239 with `out_ready`=1 throughout.
  - Each word appears exactly one cycle after its write; `count` never exceeds 1.
- Reset mid-operation:
  - With 3 words queued, assert `rst` for one cycle → `count`=0, `out_valid`=0, `overflow`=0.
  - Next write 16'h0003 → it is the head.
- Empty-output behaviour:
  - Pop 16'h1234, then leave the queue empty.
  - `out_data`=16'h1234 with `OUT_PORT_HOLD_LAST_EN` defined; 16'h0000 without.
